cla_wide_add_sequencer: RTL and testbench
=========================================

CLA_WIDE_ADD_SEQUENCER -- requirements
Module: cla_wide_add_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the adder slice width in bits.
REQ-002 The block SHALL have parameter NWORDS, default 4, giving the operand width in slices (NWORDS >= 2).
REQ-003 The block SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-004 Ports, as name / direction / width / meaning:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand request valid
- in_ready  out  1  block can accept an operand request
- in_a  in  WIDTH*NWORDS  operand A
- in_b  in  WIDTH*NWORDS  operand B
- in_cin  in  1  carry into bit 0
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sum  out  WIDTH*NWORDS  registered sum
- out_cout  out  1  registered carry out of the top bit
- busy  out  1  high in RUN or DONE
- add_a  out  WIDTH  slice operand A, drives carry_lookahead_adder.a
- add_b  out  WIDTH  slice operand B, drives carry_lookahead_adder.b
- add_cin  out  1  slice carry, drives carry_lookahead_adder.carry_in
- add_sum  in  WIDTH  slice sum, from carry_lookahead_adder.sum
- add_cout  in  1  slice carry, from carry_lookahead_adder.carry_out

Function
REQ-005 The external adder SHALL be treated as purely combinational: add_sum/add_cout are sampled in the same cycle add_a/add_b/add_cin are driven.
REQ-006 The FSM SHALL have three states:
- IDLE: in_ready=1, out_valid=0, busy=0
- RUN: in_ready=0, out_valid=0, busy=1
- DONE: in_ready=0, out_valid=1, busy=1
REQ-007 IDLE to RUN on in_valid && in_ready. In that transition the block SHALL latch in_a, in_b, carry register <= in_cin, word index <= 0, and result register <= 0.
REQ-008 In RUN, the block SHALL drive add_a and add_b from latched word[idx] (bits idx*WIDTH +: WIDTH) and add_cin from the carry register.
REQ-009 Each RUN cycle, the block SHALL write result word[idx] <= add_sum and carry <= add_cout, then idx <= idx+1.
REQ-010 RUN to DONE SHALL occur on the cycle that processes idx == NWORDS-1; out_cout then equals the final add_cout.
REQ-011 Latency: with acceptance at edge T, out_valid SHALL first be high after edge T+NWORDS (exactly NWORDS RUN cycles).
REQ-012 In DONE, out_sum, out_cout and out_valid SHALL hold stable until out_valid && out_ready; on that edge the FSM SHALL return to IDLE.
REQ-013 A new request SHALL not be accepted in the handshake cycle; the earliest next acceptance is the following cycle (IDLE).
REQ-014 Outside RUN, add_a, add_b and add_cin SHALL be driven to 0.
REQ-015 out_sum/out_cout SHALL change only during RUN updates or reset; they hold the last result while in IDLE.
REQ-016 in_a/in_b/in_cin changes after acceptance SHALL have no effect on the in-flight operation.
REQ-017 The index counter SHALL be ceil(log2(NWORDS)) bits wide (minimum 1) and SHALL never exceed NWORDS-1.
REQ-018 The arithmetic result SHALL equal (in_a + in_b + in_cin) mod 2^(WIDTH*NWORDS), and out_cout SHALL be the carry out of the full width.

Reset
REQ-019 When rst is high at a clock edge, the block SHALL enter IDLE with idx=0, carry=0, out_sum=0, out_cout=0, out_valid=0, busy=0, and in_ready=1 in the following cycle.
REQ-020 rst SHALL take priority over all other inputs in any state.
REQ-021 A reset in RUN or DONE SHALL discard the in-flight operation with no out_valid pulse.

Verification (WIDTH=8, NWORDS=4, adder instance connected)
REQ-022 Carry ripple: accept A=0xFFFFFFFF, B=0x00000001, cin=0 -> out_valid after exactly 4 RUN cycles; out_sum=0x00000000, out_cout=1; add_cin sequence 0,1,1,1.
REQ-023 Plain add: A=0x12345678, B=0x11111111, cin=1 -> out_sum=0x2345678A, out_cout=0; add_a sequence 0x78,0x56,0x34,0x12.
REQ-024 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, out_sum stable, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-025 Reset mid-RUN: assert rst at idx=2 -> next cycle IDLE, out_sum=0, out_cout=0, no out_valid pulse; a following request A=0x00000001, B=0x00000001, cin=0 completes with out_sum=0x00000002.
REQ-026 Back-to-back: in_valid held high with out_ready=1 -> accepts are spaced exactly NWORDS+2 = 6 cycles apart; every result matches a reference model over 1000 random A/B/cin.

Source files
------------

// File: rtl/cla_wide_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cla_wide_add_sequencer
// Purpose  : Builds a WIDTH*NWORDS-bit add out of one external WIDTH-bit
//            combinational carry-lookahead adder. Each operand is consumed one
//            slice per clock, least-significant slice first, with the slice
//            carry rippled through a register between cycles.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1              clock, all state on rising edge
//   rst        in   1              synchronous active-high reset
//   in_valid   in   1              operand request valid
//   in_ready   out  1              request can be accepted (IDLE)
//   in_a       in   WIDTH*NWORDS   operand A
//   in_b       in   WIDTH*NWORDS   operand B
//   in_cin     in   1              carry into bit 0
//   out_valid  out  1              result valid (DONE)
//   out_ready  in   1              consumer accepts result
//   out_sum    out  WIDTH*NWORDS   registered sum
//   out_cout   out  1              registered carry out of the top bit
//   busy       out  1              high in RUN or DONE
//   add_a      out  WIDTH          slice operand A to external adder
//   add_b      out  WIDTH          slice operand B to external adder
//   add_cin    out  1              slice carry to external adder
//   add_sum    in   WIDTH          slice sum from external adder
//   add_cout   in   1              slice carry from external adder
// ============================================================================
module cla_wide_add_sequencer #(
  parameter int WIDTH  = 8,
  parameter int NWORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH*NWORDS-1:0]   in_a,
  input  logic [WIDTH*NWORDS-1:0]   in_b,
  input  logic                      in_cin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH*NWORDS-1:0]   out_sum,
  output logic                      out_cout,
  output logic                      busy,
  output logic [WIDTH-1:0]          add_a,
  output logic [WIDTH-1:0]          add_b,
  output logic                      add_cin,
  input  logic [WIDTH-1:0]          add_sum,
  input  logic                      add_cout
);

  localparam int C_TOTAL = WIDTH * NWORDS;
  localparam int C_IDXW  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [C_IDXW-1:0] C_LAST_IDX = C_IDXW'(NWORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;

  logic [C_TOTAL-1:0]    r_a;
  logic [C_TOTAL-1:0]    r_b;
  logic [C_TOTAL-1:0]    r_sum;
  logic                  r_cout;
  logic                  r_carry;
  logic [C_IDXW-1:0]     r_idx;

  logic [WIDTH-1:0]      w_word_a;
  logic [WIDTH-1:0]      w_word_b;
  logic                  w_last;
  logic                  w_accept;

  assign out_sum  = r_sum;
  assign out_cout = r_cout;
  assign w_last   = (r_idx == C_LAST_IDX);
  assign w_accept = (r_state == S_IDLE) && in_valid;

  // Slice select from the latched operands. Written as a compare-per-word mux
  // so the index never has to be widened for a variable part-select.
  always_comb begin
    w_word_a = '0;
    w_word_b = '0;
    for (int w = 0; w < NWORDS; w++) begin
      if (r_idx == C_IDXW'(w)) begin
        w_word_a = r_a[w*WIDTH +: WIDTH];
        w_word_b = r_b[w*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state and Moore outputs. The adder inputs are only live in RUN so
  // the external adder sees a quiet zero operand at all other times.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    add_a        = '0;
    add_b        = '0;
    add_cin      = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy    = 1'b1;
        add_a   = w_word_a;
        add_b   = w_word_b;
        add_cin = r_carry;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        // Handshake returns to IDLE; the next request is seen one cycle later.
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath. Operands are captured on acceptance so later changes on
  // in_a/in_b/in_cin cannot disturb an operation already in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_carry <= in_cin;
            r_idx   <= '0;
            r_sum   <= '0;
          end
        end
        S_RUN: begin
          for (int w = 0; w < NWORDS; w++) begin
            if (r_idx == C_IDXW'(w)) begin
              r_sum[w*WIDTH +: WIDTH] <= add_sum;
            end
          end
          r_carry <= add_cout;
          if (w_last) begin
            // Wrap to zero rather than incrementing so the index stays in range.
            r_cout <= add_cout;
            r_idx  <= '0;
          end else begin
            r_idx  <= r_idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cla_wide_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_wide_add_sequencer
// Purpose  : Self-checking bench for cla_wide_add_sequencer (WIDTH=8,
//            NWORDS=4). A behavioural slice adder stands in for the external
//            carry-lookahead adder. Expected results are queued on acceptance
//            and compared when the result handshake occurs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla_wide_add_sequencer;

  localparam int WIDTH  = 8;
  localparam int NWORDS = 4;
  localparam int TOTAL  = WIDTH * NWORDS;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [TOTAL-1:0] in_a;
  logic [TOTAL-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [TOTAL-1:0] out_sum;
  logic             out_cout;
  logic             busy;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  int               n_checks = 0;
  int               n_errors = 0;
  int               cyc = 0;
  logic [TOTAL:0]   sb[$];
  logic [TOTAL:0]   mon_exp;

  cla_wide_add_sequencer #(.WIDTH(WIDTH), .NWORDS(NWORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout)
  );

  // Combinational slice adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Result monitor: one pop per completed output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_value("sb_unexpected_result", 64'd1, 64'd0);
      end else begin
        mon_exp = sb.pop_front();
        check_value("result", {31'd0, out_cout, out_sum}, {31'd0, mon_exp});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request (caller is just after a rising edge), wait for it to be
  // taken, queue the reference result, and return just after the accept edge.
  task automatic send(input logic [TOTAL-1:0] a, input logic [TOTAL-1:0] b,
                      input logic cin, input bit keep_valid, output int t_acc);
    int k;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_valid = 1'b1;
    k = 0;
    t_acc = -1;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      check_value("accept_timeout", 64'd0, 64'd1);
    end else begin
      sb.push_back({1'b0, a} + {1'b0, b} + {{TOTAL{1'b0}}, cin});
      t_acc = cyc;
    end
    step();
    if (!keep_valid) begin
      in_valid = 1'b0;
      // Disturb the inputs; the in-flight operation must not notice.
      in_a   = $urandom;
      in_b   = $urandom;
      in_cin = 1'($urandom_range(0, 1));
    end
  endtask

  logic [3:0]       exp_cin_seq;
  logic [WIDTH-1:0] exp_a_seq[4];
  logic [TOTAL-1:0] ra;
  logic [TOTAL-1:0] rb;
  int               t_acc;
  int               t_prev;
  int               k;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check_value("rst_in_ready", 64'(in_ready), 64'd1);
    check_value("rst_out_valid", 64'(out_valid), 64'd0);
    check_value("rst_busy", 64'(busy), 64'd0);
    check_value("rst_out_sum", 64'(out_sum), 64'd0);
    check_value("rst_out_cout", 64'(out_cout), 64'd0);
    check_value("rst_add_a", 64'(add_a), 64'd0);

    // Carry ripple through every slice
    step();
    out_ready = 1'b1;
    exp_cin_seq = 4'b1110;
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, t_acc);
    for (int i = 0; i < NWORDS; i++) begin
      @(negedge clk);
      check_value("ripple_run_flags", {61'd0, busy, out_valid, in_ready}, 64'b100);
      check_value("ripple_add_cin", 64'(add_cin), 64'(exp_cin_seq[i]));
    end
    @(negedge clk);
    check_value("ripple_latency_valid", 64'(out_valid), 64'd1);
    check_value("ripple_sum", 64'(out_sum), 64'h0);
    check_value("ripple_cout", 64'(out_cout), 64'd1);

    // Plain add with carry in
    step();
    exp_a_seq = '{8'h78, 8'h56, 8'h34, 8'h12};
    send(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, t_acc);
    for (int i = 0; i < NWORDS; i++) begin
      @(negedge clk);
      check_value("plain_add_a", 64'(add_a), 64'(exp_a_seq[i]));
      check_value("plain_add_b", 64'(add_b), 64'h11);
    end
    @(negedge clk);
    check_value("plain_valid", 64'(out_valid), 64'd1);
    check_value("plain_sum", 64'(out_sum), 64'h2345_678A);
    check_value("plain_cout", 64'(out_cout), 64'd0);

    // Backpressure in DONE
    step();
    out_ready = 1'b0;
    send(32'hA0A0_A0A0, 32'h0F0F_0F0F, 1'b0, 1'b0, t_acc);
    repeat (NWORDS) @(negedge clk);
    @(negedge clk);
    check_value("bp_valid_first", 64'(out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_value("bp_valid_hold", 64'(out_valid), 64'd1);
      check_value("bp_in_ready", 64'(in_ready), 64'd0);
      check_value("bp_sum_hold", 64'(out_sum), 64'hAFAF_AFAF);
      check_value("bp_add_idle", {55'd0, add_a, add_cin}, 64'd0);
    end
    step();
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_value("bp_release_in_ready", 64'(in_ready), 64'd1);
    check_value("bp_release_valid", 64'(out_valid), 64'd0);
    check_value("bp_idle_sum_held", 64'(out_sum), 64'hAFAF_AFAF);

    // Reset in the middle of RUN (idx = 2)
    step();
    send(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, t_acc);
    step();
    step();
    rst = 1'b1;
    @(negedge clk);
    check_value("mid_rst_busy_before", 64'(busy), 64'd1);
    step();
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check_value("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check_value("mid_rst_sum", 64'(out_sum), 64'd0);
    check_value("mid_rst_cout", 64'(out_cout), 64'd0);
    check_value("mid_rst_busy", 64'(busy), 64'd0);
    for (int i = 0; i < NWORDS + 1; i++) begin
      @(negedge clk);
      check_value("mid_rst_no_valid", 64'(out_valid), 64'd0);
    end
    step();
    send(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, t_acc);
    repeat (NWORDS + 1) @(negedge clk);
    check_value("post_rst_sum", 64'(out_sum), 64'h2);

    // Back-to-back random traffic
    step();
    out_ready = 1'b1;
    t_prev = -1;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      send(ra, rb, 1'($urandom_range(0, 1)), 1'b1, t_acc);
      if (t_prev >= 0) begin
        check_value("b2b_spacing", 64'(t_acc - t_prev), 64'(NWORDS + 2));
      end
      t_prev = t_acc;
    end
    in_valid = 1'b0;
    k = 0;
    while (sb.size() > 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_value("drain_sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
